// File: rtl/regression_sample_feeder_pkg.sv
// Shared constants, FSM state type and x saturation helper for the regression sample feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regression_sample_feeder_pkg;

    localparam int N     = 256;  // samples per regression burst
    localparam int AW    = 8;    // log2(N)
    localparam int XW    = 16;   // stored x, unsigned 12.4
    localparam int YW    = 16;   // stored y, passed through untouched
    localparam int XTX_W = 12;   // x as seen by the X^T X accumulator, 8.4

    localparam logic [XTX_W-1:0] X_SAT_VAL = 12'hFFF;

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        STREAM,
        WAIT
    } state_t;

    // 12.4 -> 8.4: any set bit above the 8 integer bits clamps to full scale.
    function automatic logic [XTX_W-1:0] sat_x(input logic [XW-1:0] x);
        return (x[XW-1:XTX_W] != '0) ? X_SAT_VAL : x[XTX_W-1:0];
    endfunction

endpackage

// File: rtl/regression_sample_feeder_sample_buffer.sv
// N x (XW+YW) sample store: one write port, one synchronous read port.
// Latency: read data appears the cycle after i_re; rdata is 0 whenever i_re was low.
// Backpressure: none; accepts a write every cycle.
// Ports: clk, rst_n (async, active-low; clears rdata only), i_we/i_waddr/i_wdata write,
//        i_re/i_raddr read request, o_rdata registered read data.
module regression_sample_feeder_sample_buffer
    import regression_sample_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [XW+YW-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [XW+YW-1:0] o_rdata
);

    // Storage is deliberately not reset: the feeder never reads it before it
    // has been completely rewritten after a reset.
    logic [XW+YW-1:0] r_mem [N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register doubles as the feeder's output register, so it drops
    // to zero on any cycle without a read request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= i_re ? r_mem[i_raddr] : '0;
        end
    end

endmodule

// File: rtl/regression_sample_feeder.sv
// Buffers N (x,y) samples, then replays them as one gap-free burst after a start pulse.
// Latency: acc_start the cycle after the last write or replay request; samples on the N following cycles.
// Backpressure: wr_ready high only in FILL (low in a replay-win cycle); the burst itself cannot be stalled.
// Ports: producer i_wr_valid/o_wr_ready/i_wr_x/i_wr_y, i_replay, accumulator side o_acc_start,
//        o_xtx_x (saturated 8.4), o_xty_x, o_xty_y, o_streaming, o_x_sat, i_acc_done, o_done.
module regression_sample_feeder
    import regression_sample_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    input  logic [XW-1:0]    i_wr_x,
    input  logic [YW-1:0]    i_wr_y,
    input  logic             i_replay,
    input  logic             i_acc_done,
    output logic             o_acc_start,
    output logic [XTX_W-1:0] o_xtx_x,
    output logic [XW-1:0]    o_xty_x,
    output logic [YW-1:0]    o_xty_y,
    output logic             o_streaming,
    output logic             o_x_sat,
    output logic             o_done
);

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_wr_cnt;
    logic [AW-1:0]    r_rd_ptr;
    logic             r_buf_full;
    logic             r_x_sat;
    logic             r_done;

    logic             w_replay_win;
    logic             w_we;
    logic             w_re;
    logic             w_last;
    logic             w_sat;
    logic [XW+YW-1:0] w_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_wr_ready   = 1'b0;
        o_acc_start  = 1'b0;
        o_streaming  = 1'b0;
        w_replay_win = 1'b0;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            FILL: begin
                // Replay is only meaningful on a complete, untouched buffer.
                w_replay_win = i_replay & r_buf_full & (r_wr_cnt == '0);
                o_wr_ready   = ~w_replay_win;
                w_we         = i_wr_valid & ~w_replay_win;
                if (w_replay_win || (w_we && r_wr_cnt == AW'(N-1))) begin
                    w_next = LAUNCH;
                end
            end
            LAUNCH: begin
                o_acc_start = 1'b1;
                w_re        = 1'b1;   // rd_ptr is 0 here: fetch sample 0
                w_next      = STREAM;
            end
            STREAM: begin
                o_streaming = 1'b1;
                // rd_ptr runs 1..N-1 and wraps to 0 exactly on the cycle
                // presenting sample N-1; no further fetch then.
                w_last      = (r_rd_ptr == '0);
                w_re        = ~w_last;
                if (w_last) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (i_acc_done) begin
                    w_next = FILL;
                end
            end
            default: w_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt   <= '0;
            r_rd_ptr   <= '0;
            r_buf_full <= 1'b0;
            r_x_sat    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_cnt <= r_wr_cnt + AW'(1);
                if (r_wr_cnt == AW'(N-1)) begin
                    r_buf_full <= 1'b1;
                end
            end
            if (w_re) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (o_acc_start) begin
                r_x_sat <= 1'b0;
            end else if (o_streaming && w_sat) begin
                r_x_sat <= 1'b1;
            end
            r_done <= (r_state == WAIT) && i_acc_done;
        end
    end

    regression_sample_feeder_sample_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_wr_cnt),
        .i_wdata ({i_wr_x, i_wr_y}),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign o_xty_x = w_rdata[XW+YW-1:YW];
    assign o_xty_y = w_rdata[YW-1:0];
    assign o_xtx_x = sat_x(o_xty_x);
    assign w_sat   = (o_xty_x[XW-1:XTX_W] != '0);
    // Flag is visible on the same cycle as the first saturated sample.
    assign o_x_sat = r_x_sat | (o_streaming & w_sat);
    assign o_done  = r_done;

endmodule

// File: tb/tb_regression_sample_feeder.sv
// Self-checking bench: randomized fills/bursts compared against a sample-array model.
// Latency: n/a.
// Backpressure: n/a.
module tb_regression_sample_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_x;
    logic [15:0] wr_y;
    logic        replay;
    logic        acc_done;
    logic        acc_start;
    logic [11:0] xtx_x;
    logic [15:0] xty_x;
    logic [15:0] xty_y;
    logic        streaming;
    logic        x_sat;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    // Model: contents of the last completely written buffer.
    int mx [256];
    int my [256];

    always #5 clk = ~clk;

    regression_sample_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_x      (wr_x),
        .i_wr_y      (wr_y),
        .i_replay    (replay),
        .i_acc_done  (acc_done),
        .o_acc_start (acc_start),
        .o_xtx_x     (xtx_x),
        .o_xty_x     (xty_x),
        .o_xty_y     (xty_y),
        .o_streaming (streaming),
        .o_x_sat     (x_sat),
        .o_done      (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 12.4 value above 255.9375 clamps to full 8.4 scale.
    function automatic int ref_xtx(input int x);
        return (x > 4095) ? 4095 : x;
    endfunction

    task automatic check_quiet(input string tag, input int exp_ready, input int exp_sat);
        check_val({tag, "_ready"}, wr_ready, exp_ready);
        check_val({tag, "_start"}, acc_start, 0);
        check_val({tag, "_strm"}, streaming, 0);
        check_val({tag, "_xty_x"}, xty_x, 0);
        check_val({tag, "_xty_y"}, xty_y, 0);
        check_val({tag, "_xtx_x"}, xtx_x, 0);
        check_val({tag, "_xsat"}, x_sat, exp_sat);
    endtask

    // replay with nothing stored must be ignored
    task automatic replay_empty();
        @(negedge clk);
        replay = 1'b1; wr_valid = 1'b0; #1;
        check_val("empty_replay_ready", wr_ready, 1);
        @(negedge clk);
        replay = 1'b0; #1;
        check_quiet("empty_replay_after", 1, 0);
    endtask

    // mode 0: ramp x=k<<4 y=1000+k; 1: random with sample 5 saturating; 2: random throttled
    task automatic do_fill(input int mode, input bit mid_replay);
        int acc = 0;
        int cyc = 0;
        int x;
        int y;
        while (acc < 256 && cyc < 2000) begin
            @(negedge clk);
            if (mode == 0) begin
                x = acc * 16;
                y = 1000 + acc;
            end else begin
                x = $urandom_range(0, 4095);
                y = $urandom_range(0, 65535);
                if (mode == 1 && acc == 5) x = 'h1230;
            end
            wr_valid = (mode == 2) ? ((cyc % 2) == 0) : 1'b1;
            wr_x     = 16'(x);
            wr_y     = 16'(y);
            replay   = mid_replay && (acc == 10);
            #1;
            check_val("fill_ready", wr_ready, 1);
            check_val("fill_start", acc_start, 0);
            if (wr_valid) begin
                mx[acc] = x;
                my[acc] = y;
                acc++;
            end
            cyc++;
        end
    endtask

    task automatic check_burst(input int abort_k);
        bit any_sat = 1'b0;
        int w;
        @(negedge clk);
        wr_valid = 1'($urandom_range(0, 1)); replay = 1'b0; acc_done = 1'b0; #1;
        check_val("launch_start", acc_start, 1);
        check_val("launch_strm", streaming, 0);
        check_val("launch_ready", wr_ready, 0);
        check_val("launch_xty_x", xty_x, 0);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            wr_valid = 1'($urandom_range(0, 1));
            wr_x = 16'($urandom_range(0, 65535));
            #1;
            if (mx[k] > 4095) any_sat = 1'b1;
            check_val("strm_xty_x", xty_x, mx[k]);
            check_val("strm_xty_y", xty_y, my[k]);
            check_val("strm_xtx_x", xtx_x, ref_xtx(mx[k]));
            check_val("strm_valid", streaming, 1);
            check_val("strm_start", acc_start, 0);
            check_val("strm_ready", wr_ready, 0);
            check_val("strm_xsat", x_sat, any_sat);
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1;
                check_quiet("abort", 1, 0);
                check_val("abort_done", done, 0);
                return;
            end
        end
        w = $urandom_range(1, 5);
        repeat (w) begin
            @(negedge clk);
            wr_valid = 1'($urandom_range(0, 1)); #1;
            check_quiet("wait", 0, any_sat);
            check_val("wait_done", done, 0);
        end
        @(negedge clk);
        acc_done = 1'b1; #1;
        check_val("accdone_done", done, 0);
        @(negedge clk);
        acc_done = 1'b0; wr_valid = 1'b0; #1;
        check_val("done_pulse", done, 1);
        check_quiet("done", 1, any_sat);
        @(negedge clk);
        #1;
        check_val("done_clear", done, 0);
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; replay = 1'b0; acc_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("rst", 1, 0);
        check_val("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1; #1;
        check_quiet("post_rst", 1, 0);

        replay_empty();

        do_fill(0, 1'b0);
        check_burst(-1);

        do_fill(1, 1'b0);
        check_burst(-1);

        // replay beats a simultaneous write; identical burst follows
        @(negedge clk);
        replay = 1'b1; wr_valid = 1'b1; wr_x = 16'hDEAD; wr_y = 16'hBEEF; #1;
        check_val("replay_win_ready", wr_ready, 0);
        check_burst(-1);

        // throttled producer, with a replay request mid-fill that must be ignored
        do_fill(2, 1'b1);
        check_burst(-1);

        // reset in the middle of a burst, then start over from empty
        do_fill(2, 1'b0);
        check_burst(100);
        @(negedge clk);
        rst_n = 1'b1; wr_valid = 1'b0; #1;
        check_quiet("after_abort", 1, 0);
        replay_empty();
        do_fill(1, 1'b0);
        check_burst(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regression_sample_feeder.md
# regression_sample_feeder

Buffers one exercise date's worth of Monte Carlo regression samples, 256 (x, y) pairs, as they arrive from the path simulator. It then replays them as a single back-to-back burst into the X^T X and X^T Y accumulators, which accept a one-cycle start pulse followed by exactly N consecutive samples. It is the transmitting end of the accumulator sample interface. The block also holds the buffer for optional replays and reports completion once the accumulators signal their results are valid.

## Interface
- N, 256: samples per regression burst.
- AW, 8: buffer address width, log2(N).
- XW, 16: stored x width, unsigned 12.4.
- YW, 16: stored y width, unsigned, passed through untouched.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  sample offered by the producer.
- wr_ready  out  1  buffer accepts a sample this cycle.
- wr_x  in  XW  sample x, 12.4.
- wr_y  in  YW  sample y.
- replay  in  1  re-stream the current full buffer without refilling.
- acc_done  in  1  level; AND of both accumulator valid flags.
- acc_start  out  1  one-cycle start pulse to both accumulators.
- xtx_x  out  12  x to the X^T X accumulator, 8.4, saturated.
- xty_x  out  XW  x to the X^T Y accumulator.
- xty_y  out  YW  y to the X^T Y accumulator.
- streaming  out  1  high while xtx_x, xty_x and xty_y carry valid samples.
- x_sat  out  1  sticky: at least one sample in the current burst was saturated.
- done  out  1  one-cycle pulse once the burst has been accepted downstream.

## Operation
- States: FILL, LAUNCH, STREAM, WAIT.
- Reset state is FILL with wr_cnt=0, rd_ptr=0 and buf_full=0.
- Reset values of all outputs: wr_ready=1 (FILL); acc_start, streaming, x_sat, done = 0; xtx_x, xty_x, xty_y = 0.
- FILL:
  - wr_ready = 1, except in a replay-win cycle (below).
  - A sample is written on wr_valid & wr_ready to buf[wr_cnt], then wr_cnt increments.
  - When sample N-1 is written: buf_full=1, wr_cnt wraps to 0, next state LAUNCH.
  - replay=1 with buf_full=1 and wr_cnt==0: next state LAUNCH, wr_ready=0 in that cycle, no write. Replay wins over a simultaneous write.
  - replay is ignored when buf_full=0 or wr_cnt!=0.
- LAUNCH:
  - acc_start=1 for exactly this cycle; x_sat clears.
  - The output registers load buf[0], and rd_ptr becomes 1.
  - Next state STREAM.
- STREAM:
  - streaming=1; the outputs hold sample k in the k-th STREAM cycle, k=0..N-1.
  - Each cycle loads buf[rd_ptr] and increments rd_ptr.
  - After the cycle carrying sample N-1: outputs go to 0, rd_ptr=0, next state WAIT.
- WAIT:
  - When acc_done=1: done=1 for one cycle, next state FILL. buf_full stays set, so a replay remains possible.
  - acc_done in any other state is ignored.
- Saturation: xtx_x = (x[15:12]!=0) ? 12'hFFF : x[11:0]. Any saturation during STREAM sets x_sat, which holds until the next LAUNCH.
- xty_x and xty_y are the stored values, unmodified.
- wr_valid is ignored outside FILL; wr_ready is 0 there.
- Reset mid-operation clears state, counters and outputs immediately. Buffer contents are not reset and are never read before being rewritten, because buf_full=0 after reset.

## Timing
- Cycle L (LAUNCH): acc_start=1.
- Cycles L+1 .. L+N: samples 0..N-1 are presented with no gaps. This matches the accumulator entering its input state the cycle after it samples start.
- Cycle L+N+1 onward: outputs 0, streaming=0.
- Fill-to-start latency: the last sample is accepted at edge E, and acc_start is high in the cycle following E.
- Replay-to-start latency: 1 cycle.
- done asserts in the cycle after acc_done is first sampled high in WAIT.
- Minimum throughput: one write per cycle in FILL.

## Structure
- Shared package holds N, AW, XW, YW, the state enum (FILL, LAUNCH, STREAM, WAIT) and the 12'hFFF saturation constant.
- Sub-module sample_buffer: N x (XW+YW) register array with one write port (we, waddr, wdata) and one synchronous read port (raddr, rdata registered).

## Test plan
- Reset, then 256 writes with x=k<<4, y=1000+k, wr_valid held high.
  - acc_start pulses the cycle after the 256th write.
  - The next 256 cycles show xty_x=k<<4, xty_y=1000+k, xtx_x=(k<<4)[11:0].
  - done pulses after acc_done=1; x_sat=0.
- Sample 5 with x=16'h1230 → xtx_x=12'hFFF on the 6th stream cycle, xty_x=16'h1230, x_sat=1 until the next LAUNCH.
- After done, assert replay=1 and wr_valid=1 in the same cycle → wr_ready=0, acc_start the next cycle, identical 256-sample burst.
- replay=1 right after reset (buffer empty) → ignored, no acc_start; wr_ready stays 1.
- Producer throttled with wr_valid toggling every other cycle → exactly 256 accepted writes, burst still gap-free, wr_ready=0 throughout STREAM.
- rst_n low during STREAM at k=100 → all outputs 0 at once, state FILL, buf_full=0; a fresh full fill afterwards streams correctly.
